// File: rtl/aes_enc_pkg.sv
// Shared types, schedule constants and GF(2^8) helpers for the word-serial AES-128 encryptor.
// Pure declarations: no state, no handshake.
package aes_enc_pkg;

   localparam int NR       = 10;
   localparam int RCYC     = 6;
   localparam int LOAD_CYC = 4;
   localparam int OUT_CYC  = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_LOAD,
      S_ROUND,
      S_FINAL,
      S_OUT
   } state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Column bytes are ordered row 0 in the MSB down to row 3 in the LSB.
   function automatic logic [31:0] mixcol(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box: GF(2^8) inverse (x^254) followed by the affine map.
// Zero latency, no flow control.
module aes_sbox
   import aes_enc_pkg::*;
(
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = gf_mul(x, x);
      acc = sq;
      for (int k = 2; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   logic [7:0] w_inv;

   assign w_inv  = gf_inv(i_byte);
   assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                 ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_word_enc_core.sv
// AES-128 encryptor, 32-bit words in/out MSW first; 72 cycles from start edge to last output word.
// No backpressure: start taken only in IDLE; define AES_OUT_CLEAR_EN to zero data_out outside OUT.
module aes_word_enc_core
   import aes_enc_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         selEncDec,
   input  logic [127:0] key_in,
   input  logic [31:0]  data_in,
   output logic [31:0]  data_out,
   output logic [6:0]   signals
);

   state_t       r_state;
   state_t       w_state_nxt;
   logic [2:0]   r_cnt;
   logic [3:0]   r_rnd;
   logic [127:0] r_key;
   logic [127:0] r_rk;
   logic [127:0] r_st;
   logic [127:0] r_nst;
   logic [7:0]   r_rcon;
   logic         r_kv;
   logic         r_done;
   logic         r_ov;
   logic [31:0]  r_dout;

   logic [1:0]   w_ci;
   logic [7:0]   w_sb_in  [4];
   logic [7:0]   w_sb_out [4];
   logic [31:0]  w_sub;
   logic [31:0]  w_col;
   logic [31:0]  w_tmp;
   logic [31:0]  w_k0, w_k1, w_k2, w_k3;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start && !selEncDec)          w_state_nxt = S_SETUP;
         S_SETUP: if (r_cnt == 3'd1)                w_state_nxt = S_LOAD;
         S_LOAD:  if (r_cnt == 3'(LOAD_CYC - 1))    w_state_nxt = S_ROUND;
         S_ROUND: if (r_cnt == 3'(RCYC - 1) && r_rnd == 4'(NR)) w_state_nxt = S_FINAL;
         S_FINAL:                                   w_state_nxt = S_OUT;
         S_OUT:   if (r_cnt == 3'(OUT_CYC - 1))     w_state_nxt = S_IDLE;
         default:                                   w_state_nxt = S_IDLE;
      endcase
   end

   assign w_ci = r_cnt[1:0];

   // Column cycles feed ShiftRows-selected bytes; the key cycle feeds RotWord(w3).
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         w_sb_in[r] = r_st[8 * (15 - 4 * ((int'(w_ci) + r) % 4) - r) +: 8];
      end
      if (r_cnt == 3'd4) begin
         w_sb_in[0] = r_rk[23:16];
         w_sb_in[1] = r_rk[15:8];
         w_sb_in[2] = r_rk[7:0];
         w_sb_in[3] = r_rk[31:24];
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
         .i_byte (w_sb_in[g]),
         .o_byte (w_sb_out[g])
      );
   end

   assign w_sub = {w_sb_out[0], w_sb_out[1], w_sb_out[2], w_sb_out[3]};
   assign w_col = (r_rnd == 4'(NR)) ? w_sub : mixcol(w_sub);
   assign w_tmp = w_sub ^ {r_rcon, 24'h000000};
   assign w_k0  = r_rk[127:96] ^ w_tmp;
   assign w_k1  = r_rk[95:64]  ^ w_k0;
   assign w_k2  = r_rk[63:32]  ^ w_k1;
   assign w_k3  = r_rk[31:0]   ^ w_k2;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= '0;
         r_rnd  <= '0;
         r_key  <= '0;
         r_rk   <= '0;
         r_st   <= '0;
         r_nst  <= '0;
         r_rcon <= '0;
         r_kv   <= 1'b0;
         r_done <= 1'b0;
         r_ov   <= 1'b0;
         r_dout <= '0;
      end else begin
         if (w_state_nxt != r_state || (r_state == S_ROUND && r_cnt == 3'(RCYC - 1)))
            r_cnt <= '0;
         else if (r_state != S_IDLE)
            r_cnt <= r_cnt + 3'd1;

         case (r_state)
            S_IDLE: begin
               r_kv   <= 1'b0;
               r_done <= 1'b0;
               r_ov   <= 1'b0;
               r_rnd  <= '0;
               if (start && !selEncDec) r_key <= key_in;
            end
            S_SETUP: begin
               r_rk   <= r_key;
               r_rcon <= 8'h01;
               r_kv   <= 1'b1;
            end
            S_LOAD: begin
               r_st[32 * (3 - int'(w_ci)) +: 32] <= data_in ^ r_rk[32 * (3 - int'(w_ci)) +: 32];
               if (w_state_nxt == S_ROUND) r_rnd <= 4'd1;
            end
            S_ROUND: begin
               if (r_cnt < 3'd4) begin
                  r_nst[32 * (3 - int'(w_ci)) +: 32] <= w_col;
               end else if (r_cnt == 3'd4) begin
                  r_rk   <= {w_k0, w_k1, w_k2, w_k3};
                  r_rcon <= xtime(r_rcon);
               end else begin
                  r_st  <= r_nst ^ r_rk;
                  r_rnd <= (r_rnd == 4'(NR)) ? 4'd0 : r_rnd + 4'd1;
               end
            end
            S_FINAL: r_done <= 1'b1;
            S_OUT: begin
               r_ov   <= 1'b1;
               r_dout <= r_st[32 * (3 - int'(w_ci)) +: 32];
            end
            default: ;
         endcase

`ifdef AES_OUT_CLEAR_EN
         if (r_state != S_OUT) r_dout <= '0;
`endif
      end
   end

   assign data_out = r_dout;
   assign signals  = {r_ov, r_done, r_rnd, r_kv};

endmodule

// File: tb/tb_aes_word_enc_core.sv
// Bench for aes_word_enc_core: AES-128 known-answer jobs, back-to-back starts, mid-job reset
// and decrypt-mode requests.
module tb_aes_word_enc_core;

   logic         clk;
   logic         reset;
   logic         start;
   logic         selEncDec;
   logic [127:0] key_in;
   logic [31:0]  data_in;
   logic [31:0]  data_out;
   logic [6:0]   signals;

   int total = 0;
   int bad   = 0;

   localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C_ZRO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   aes_word_enc_core dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .selEncDec (selEncDec),
      .key_in    (key_in),
      .data_in   (data_in),
      .data_out  (data_out),
      .signals   (signals)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One job whose first edge is E1; returns just after E72. key_in is scrambled after E1.
   task automatic do_job(input logic [127:0] key, input logic [127:0] pt, input bit noisy,
                         output logic [127:0] ct, output logic [6:0] s_r1,
                         output logic [6:0] s_r10, output logic [6:0] s_fin,
                         output logic [27:0] s_out);
      selEncDec = 1'b0;
      start     = 1'b1;
      key_in    = key;
      tick();
      key_in = ~key;
      ct     = '0;
      s_r1   = '0;
      s_r10  = '0;
      s_fin  = '0;
      s_out  = '0;
      for (int e = 2; e <= 72; e++) begin
         start = noisy && (e <= 4 || e == 30 || e == 50);
         if (e >= 4 && e <= 7) data_in = pt[32 * (7 - e) +: 32];
         else                  data_in = $urandom();
         tick();
         if (e == 8)  s_r1  = signals;
         if (e == 62) s_r10 = signals;
         if (e == 68) s_fin = signals;
         if (e >= 69) begin
            ct[32 * (72 - e) +: 32]   = data_out;
            s_out[7 * (72 - e) +: 7]  = signals;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      total++;
      if (data_out !== 32'h0) begin
         bad++;
         $display("FAIL reset_dout got=%h want=%h", data_out, 32'h0);
      end
      total++;
      if (signals !== 7'h00) begin
         bad++;
         $display("FAIL reset_signals got=%b want=%b", signals, 7'h00);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_zero_vector();
      logic [127:0] ct;
      logic [6:0]   s1, s10, sf;
      logic [27:0]  so;
      logic [31:0]  want_hold;
      do_job(128'h0, 128'h0, 1'b0, ct, s1, s10, sf, so);
      total++;
      if (ct !== C_ZRO) begin
         bad++;
         $display("FAIL zero_ct got=%h want=%h", ct, C_ZRO);
      end
      total++;
      if (s1 !== 7'b0000011) begin
         bad++;
         $display("FAIL zero_sig_round1 got=%b want=%b", s1, 7'b0000011);
      end
      total++;
      if (s10 !== 7'b0010101) begin
         bad++;
         $display("FAIL zero_sig_round10 got=%b want=%b", s10, 7'b0010101);
      end
      total++;
      if (sf !== 7'b0100001) begin
         bad++;
         $display("FAIL zero_sig_final got=%b want=%b", sf, 7'b0100001);
      end
      total++;
      if (so !== {4{7'b1100001}}) begin
         bad++;
         $display("FAIL zero_sig_out got=%h want=%h", so, {4{7'b1100001}});
      end
      tick();
      total++;
      if (signals !== 7'h00) begin
         bad++;
         $display("FAIL zero_sig_idle got=%b want=%b", signals, 7'h00);
      end
`ifdef AES_OUT_CLEAR_EN
      want_hold = 32'h0;
`else
      want_hold = 32'hca342b2e;
`endif
      total++;
      if (data_out !== want_hold) begin
         bad++;
         $display("FAIL zero_dout_idle got=%h want=%h", data_out, want_hold);
      end
   endtask

   task automatic test_fips_c1();
      logic [127:0] ct;
      logic [6:0]   s1, s10, sf;
      logic [27:0]  so;
      do_job(K_C1, P_C1, 1'b0, ct, s1, s10, sf, so);
      total++;
      if (ct !== C_C1) begin
         bad++;
         $display("FAIL c1_ct got=%h want=%h", ct, C_C1);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [127:0] ct;
      logic [6:0]   s1, s10, sf;
      logic [27:0]  so;
      do_job(K_B, P_B, 1'b0, ct, s1, s10, sf, so);
      total++;
      if (ct !== C_B) begin
         bad++;
         $display("FAIL b2b_first_ct got=%h want=%h", ct, C_B);
      end
      do_job(K_C1, P_C1, 1'b1, ct, s1, s10, sf, so);
      total++;
      if (ct !== C_C1) begin
         bad++;
         $display("FAIL b2b_second_ct got=%h want=%h", ct, C_C1);
      end
      total++;
      if (so !== {4{7'b1100001}}) begin
         bad++;
         $display("FAIL b2b_sig_out got=%h want=%h", so, {4{7'b1100001}});
      end
   endtask

   task automatic test_reset_mid();
      logic [127:0] ct;
      logic [6:0]   s1, s10, sf;
      logic [27:0]  so;
      selEncDec = 1'b0;
      start     = 1'b1;
      key_in    = K_B;
      tick();
      start = 1'b0;
      for (int e = 2; e <= 29; e++) begin
         if (e >= 4 && e <= 7) data_in = P_B[32 * (7 - e) +: 32];
         else                  data_in = $urandom();
         tick();
      end
      reset = 1'b1;
      tick();
      total++;
      if (data_out !== 32'h0) begin
         bad++;
         $display("FAIL midreset_dout got=%h want=%h", data_out, 32'h0);
      end
      total++;
      if (signals !== 7'h00) begin
         bad++;
         $display("FAIL midreset_signals got=%b want=%b", signals, 7'h00);
      end
      reset = 1'b0;
      tick();
      do_job(K_B, P_B, 1'b0, ct, s1, s10, sf, so);
      total++;
      if (ct !== C_B) begin
         bad++;
         $display("FAIL midreset_fresh_ct got=%h want=%h", ct, C_B);
      end
   endtask

   task automatic test_dec_ignored();
      logic [127:0] ct;
      logic [6:0]   s1, s10, sf;
      logic [27:0]  so;
      selEncDec = 1'b1;
      start     = 1'b1;
      key_in    = K_B;
      for (int i = 0; i < 4; i++) tick();
      total++;
      if (signals !== 7'h00) begin
         bad++;
         $display("FAIL dec_signals got=%b want=%b", signals, 7'h00);
      end
      do_job(K_C1, P_C1, 1'b0, ct, s1, s10, sf, so);
      total++;
      if (ct !== C_C1) begin
         bad++;
         $display("FAIL dec_then_enc_ct got=%h want=%h", ct, C_C1);
      end
      tick();
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      selEncDec = 1'b0;
      key_in    = '0;
      data_in   = '0;
      test_reset();
      test_zero_vector();
      test_fips_c1();
      test_back_to_back();
      test_reset_mid();
      test_dec_ignored();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
